// File: rtl/serial_frame_sender_if.sv
// Request and serial-line bundle for serial_frame_sender.
// The master side drives requests; the slave side drives the line.
interface serial_frame_sender_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              Start;
  logic [1:0]        PortIn;
  logic [CNT_W-1:0]  CountIn;
  logic [DATA_W-1:0] DataIn;
  logic              SerOut;
  logic              Busy;
  logic              DataPhase;
  logic              Done;

  modport master (
    output Start, PortIn, CountIn, DataIn,
    input  SerOut, Busy, DataPhase, Done
  );

  modport slave (
    input  Start, PortIn, CountIn, DataIn,
    output SerOut, Busy, DataPhase, Done
  );
endinterface

// File: rtl/serial_frame_sender.sv
// Frame serializer: start bit, 2-bit port, count field, N data bits.
// MSB-first, one bit per enabled clock, line idles high.
module serial_frame_sender #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clkEn,
  serial_frame_sender_if.slave bus
);

  localparam int MAXB = (CNT_W > 15) ? CNT_W : 15;
  localparam int IW   = $clog2(MAXB + 1);
  localparam int DIW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CIW  = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    CNT,
    DATA
  } state_t;

  state_t            state;
  logic [1:0]        port_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [IW-1:0]     idx;
  logic              ser_q;
  logic              busy_q;
  logic              dp_q;
  logic              done_q;

  logic [IW-1:0]     idx_m1;
  logic [IW-1:0]     cnt_m1;

  // Index of the next lower bit in the field being sent
  always_comb begin
    idx_m1 = idx - IW'(1);
    cnt_m1 = IW'(cnt_q) - IW'(1);
  end

  // Frame FSM; the state names what is currently on the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      port_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      idx    <= '0;
      ser_q  <= 1'b1;
      busy_q <= 1'b0;
      dp_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clkEn) begin
        unique case (state)
          IDLE: begin
            if (bus.Start) begin
              port_q <= bus.PortIn;
              cnt_q  <= bus.CountIn;
              data_q <= bus.DataIn;
              ser_q  <= 1'b0;
              busy_q <= 1'b1;
              state  <= START;
            end
          end
          START: begin
            ser_q <= port_q[1];
            idx   <= IW'(1);
            state <= PORT;
          end
          PORT: begin
            if (idx != '0) begin
              ser_q <= port_q[0];
              idx   <= '0;
            end else begin
              ser_q <= cnt_q[CNT_W-1];
              idx   <= IW'(CNT_W - 1);
              state <= CNT;
            end
          end
          CNT: begin
            if (idx != '0) begin
              ser_q <= cnt_q[CIW'(idx_m1)];
              idx   <= idx_m1;
            end else if (cnt_q == '0) begin
              ser_q  <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              ser_q <= data_q[DIW'(cnt_m1)];
              dp_q  <= 1'b1;
              idx   <= cnt_m1;
              state <= DATA;
            end
          end
          DATA: begin
            if (idx != '0) begin
              ser_q <= data_q[DIW'(idx_m1)];
              idx   <= idx_m1;
            end else begin
              ser_q  <= 1'b1;
              busy_q <= 1'b0;
              dp_q   <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
          default: begin
            ser_q  <= 1'b1;
            busy_q <= 1'b0;
            dp_q   <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.SerOut    = ser_q;
  assign bus.Busy      = busy_q;
  assign bus.DataPhase = dp_q;
  assign bus.Done      = done_q;

endmodule
